// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control side of a 5-stage MIPS pipeline.
// Carries the decoder's EX/M/WB control bundles through ID/EX, EX/MEM and
// MEM/WB. It also owns load-use stalls, the branch flush, and the freeze
// while data memory inserts wait states.
module ctrl_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ex_in,
    input  logic [2:0]       m_in,
    input  logic [1:0]       wb_in,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             mem_zero,
    input  logic             mem_ready,
    output logic             ex_reg_dst,
    output logic             ex_alu_op,
    output logic             ex_alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_src,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_dest,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Bundle bit positions: EX={RegDst,ALUOp,ALUSrc}, M={Branch,MemRead,MemWrite},
    // WB={RegWrite,MemtoReg}
    localparam int EX_REGDST  = 2;
    localparam int EX_ALUOP   = 1;
    localparam int EX_ALUSRC  = 0;
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    localparam int WB_REGWR   = 1;
    localparam int WB_MEM2REG = 0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       idexEx_q, idexEx_d;
    logic [2:0]       idexM_q, idexM_d;
    logic [1:0]       idexWb_q, idexWb_d;
    logic [REG_W-1:0] idexDest_q, idexDest_d;
    logic [2:0]       exmemM_q, exmemM_d;
    logic [1:0]       exmemWb_q, exmemWb_d;
    logic [REG_W-1:0] exmemDest_q, exmemDest_d;
    logic [1:0]       memwbWb_q, memwbWb_d;
    logic [REG_W-1:0] memwbDest_q, memwbDest_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic [REG_W-1:0] idDest;
    logic             loadUse;
    logic             branchTaken;
    logic             memWait;

    // Destination register of the instruction in ID and the three hazard terms.
    // A bundle without RegWrite gets dest 0, so its RegDst bit never matters.
    always_comb begin
        idDest = '0;
        if (wb_in[WB_REGWR]) begin
            idDest = ex_in[EX_REGDST] ? id_rd : id_rt;
        end
        loadUse     = idexM_q[M_MEMREAD] && (idexDest_q != '0) &&
                      ((idexDest_q == id_rs) || (idexDest_q == id_rt));
        branchTaken = exmemM_q[M_BRANCH] & mem_zero;
        memWait     = (exmemM_q[M_MEMREAD] | exmemM_q[M_MEMWRITE]) & ~mem_ready;
    end

    // Next contents of the pipeline registers.
    // Priority: memory wait, then branch flush, then load-use bubble.
    always_comb begin
        idexEx_d    = ex_in;
        idexM_d     = m_in;
        idexWb_d    = wb_in;
        idexDest_d  = idDest;
        exmemM_d    = idexM_q;
        exmemWb_d   = idexWb_q;
        exmemDest_d = idexDest_q;
        memwbWb_d   = exmemWb_q;
        memwbDest_d = exmemDest_q;
        if (memWait) begin
            idexEx_d    = idexEx_q;
            idexM_d     = idexM_q;
            idexWb_d    = idexWb_q;
            idexDest_d  = idexDest_q;
            exmemM_d    = exmemM_q;
            exmemWb_d   = exmemWb_q;
            exmemDest_d = exmemDest_q;
            memwbWb_d   = '0;
            memwbDest_d = '0;
        end else if (branchTaken) begin
            idexEx_d    = '0;
            idexM_d     = '0;
            idexWb_d    = '0;
            idexDest_d  = '0;
            exmemM_d    = '0;
            exmemWb_d   = '0;
            exmemDest_d = '0;
        end else if (loadUse) begin
            idexEx_d    = '0;
            idexM_d     = '0;
            idexWb_d    = '0;
            idexDest_d  = '0;
        end
    end

    // Wait-state FSM and saturating stall/freeze cycle counter.
    always_comb begin
        state_d    = memWait ? ST_WAIT : ST_RUN;
        stallCnt_d = stallCnt_q;
        if ((memWait || loadUse) && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_ONE;
        end
    end

    // State registers; reset fills every stage with a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idexEx_q    <= '0;
            idexM_q     <= '0;
            idexWb_q    <= '0;
            idexDest_q  <= '0;
            exmemM_q    <= '0;
            exmemWb_q   <= '0;
            exmemDest_q <= '0;
            memwbWb_q   <= '0;
            memwbDest_q <= '0;
            state_q     <= ST_RUN;
            stallCnt_q  <= '0;
        end else begin
            idexEx_q    <= idexEx_d;
            idexM_q     <= idexM_d;
            idexWb_q    <= idexWb_d;
            idexDest_q  <= idexDest_d;
            exmemM_q    <= exmemM_d;
            exmemWb_q   <= exmemWb_d;
            exmemDest_q <= exmemDest_d;
            memwbWb_q   <= memwbWb_d;
            memwbDest_q <= memwbDest_d;
            state_q     <= state_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign ex_reg_dst    = idexEx_q[EX_REGDST];
    assign ex_alu_op     = idexEx_q[EX_ALUOP];
    assign ex_alu_src    = idexEx_q[EX_ALUSRC];
    assign mem_read      = exmemM_q[M_MEMREAD];
    assign mem_write     = exmemM_q[M_MEMWRITE];
    assign pc_src        = branchTaken;
    assign wb_reg_write  = memwbWb_q[WB_REGWR];
    assign wb_mem_to_reg = memwbWb_q[WB_MEM2REG];
    assign wb_dest       = memwbDest_q;
    assign pc_write      = ~memWait & (branchTaken | ~loadUse);
    assign ifid_write    = ~memWait & (branchTaken | ~loadUse);
    assign ifid_flush    = ~memWait & branchTaken;
    assign mem_busy      = (state_q == ST_WAIT) | memWait;
    assign stall_cnt     = stallCnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe with a write-back scoreboard.
// A second instance with a 2-bit counter sees the same stimulus so that
// counter saturation is reachable in a few cycles.
module tb_ctrl_pipe;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;
    localparam int SAT_MAX = 3;

    localparam logic [2:0] EX_NOP = 3'b000, M_NOP = 3'b000;
    localparam logic [1:0] WB_NOP = 2'b00;
    localparam logic [2:0] EX_R = 3'b110, M_R = 3'b000;
    localparam logic [1:0] WB_R = 2'b10;
    localparam logic [2:0] EX_LW = 3'b001, M_LW = 3'b010;
    localparam logic [1:0] WB_LW = 2'b11;
    localparam logic [2:0] EX_SW = 3'b001, M_SW = 3'b001;
    localparam logic [2:0] EX_BEQ = 3'b010, M_BEQ = 3'b100;

    logic clk = 1'b0;
    logic rst;
    logic [2:0] ex_in, m_in;
    logic [1:0] wb_in;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic mem_zero, mem_ready;

    logic ex_reg_dst, ex_alu_op, ex_alu_src, mem_read, mem_write, pc_src;
    logic wb_reg_write, wb_mem_to_reg, pc_write, ifid_write, ifid_flush, mem_busy;
    logic [REG_W-1:0] wb_dest;
    logic [CNT_W-1:0] stall_cnt;

    logic sExRegDst, sExAluOp, sExAluSrc, sMemRead, sMemWrite, sPcSrc;
    logic sWbRegWrite, sWbMemToReg, sPcWrite, sIfidWrite, sIfidFlush, sMemBusy;
    logic [REG_W-1:0] sWbDest;
    logic [SAT_W-1:0] sStallCnt;

    int checks = 0;
    int errors = 0;
    int expCnt = 0;
    logic [REG_W:0] sbQ[$];
    logic [REG_W:0] expWb;

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero), .mem_ready(mem_ready),
        .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .pc_src(pc_src),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .mem_busy(mem_busy), .stall_cnt(stall_cnt)
    );

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(SAT_W)) dutSat (
        .clk(clk), .rst(rst), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero), .mem_ready(mem_ready),
        .ex_reg_dst(sExRegDst), .ex_alu_op(sExAluOp), .ex_alu_src(sExAluSrc),
        .mem_read(sMemRead), .mem_write(sMemWrite), .pc_src(sPcSrc),
        .wb_reg_write(sWbRegWrite), .wb_mem_to_reg(sWbMemToReg), .wb_dest(sWbDest),
        .pc_write(sPcWrite), .ifid_write(sIfidWrite), .ifid_flush(sIfidFlush),
        .mem_busy(sMemBusy), .stall_cnt(sStallCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ex, input logic [2:0] m,
                                 input logic [1:0] wb, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd);
        ex_in = ex;
        m_in  = m;
        wb_in = wb;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        repeat (n) tick();
    endtask

    task automatic checkStall(input string tag);
        checkOutput({tag, "_cnt"}, stall_cnt, expCnt);
        checkOutput({tag, "_cnt_sat"}, sStallCnt, (expCnt > SAT_MAX) ? SAT_MAX : expCnt);
    endtask

    // Write-back scoreboard: every register write must match the oldest
    // outstanding issued instruction, and none may appear unannounced.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_reg_write !== 1'b0) begin
            checkOutput("sb_pending", (sbQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sbQ.size() > 0) begin
                expWb = sbQ.pop_front();
                checkOutput("sb_wb_dest", wb_dest, expWb[REG_W-1:0]);
                checkOutput("sb_wb_mem_to_reg", wb_mem_to_reg, expWb[REG_W]);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem_zero = 1'b0;
        mem_ready = 1'b1;
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        #11;
        checkOutput("rst_ex_reg_dst", ex_reg_dst, 0);
        checkOutput("rst_ex_alu_op", ex_alu_op, 0);
        checkOutput("rst_ex_alu_src", ex_alu_src, 0);
        checkOutput("rst_mem_read", mem_read, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_pc_src", pc_src, 0);
        checkOutput("rst_wb_reg_write", wb_reg_write, 0);
        checkOutput("rst_wb_dest", wb_dest, 0);
        checkOutput("rst_pc_write", pc_write, 1);
        checkOutput("rst_ifid_write", ifid_write, 1);
        checkOutput("rst_ifid_flush", ifid_flush, 0);
        checkOutput("rst_mem_busy", mem_busy, 0);
        checkStall("rst");
        rst = 1'b0;

        $display("[TB] R-type without hazards");
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd5);
        sbQ.push_back({1'b0, 5'd5});
        checkOutput("r_pc_write", pc_write, 1);
        checkOutput("r_ifid_write", ifid_write, 1);
        tick();
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("r_ex_reg_dst", ex_reg_dst, 1);
        checkOutput("r_ex_alu_op", ex_alu_op, 1);
        checkOutput("r_ex_alu_src", ex_alu_src, 0);
        tick();
        checkOutput("r_ex_reg_dst_gone", ex_reg_dst, 0);
        checkOutput("r_mem_read", mem_read, 0);
        checkOutput("r_mem_write", mem_write, 0);
        tick();
        checkOutput("r_wb_reg_write", wb_reg_write, 1);
        checkOutput("r_wb_dest", wb_dest, 5);
        checkOutput("r_pc_write_late", pc_write, 1);
        drain(3);

        $display("[TB] load-use with rt=8");
        applyStimulus(EX_LW, M_LW, WB_LW, 5'd3, 5'd8, 5'd0);
        sbQ.push_back({1'b1, 5'd8});
        checkOutput("lw_pc_write", pc_write, 1);
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd8, 5'd9, 5'd10);
        checkOutput("lu_pc_write", pc_write, 0);
        checkOutput("lu_ifid_write", ifid_write, 0);
        checkOutput("lu_ifid_flush", ifid_flush, 0);
        tick();
        expCnt++;
        checkOutput("lu_bubble_alu_op", ex_alu_op, 0);
        checkOutput("lu_bubble_reg_dst", ex_reg_dst, 0);
        checkOutput("lu_lw_mem_read", mem_read, 1);
        checkStall("lu");
        checkOutput("lu_released_pc_write", pc_write, 1);
        sbQ.push_back({1'b0, 5'd10});
        tick();
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("lu_add_alu_op", ex_alu_op, 1);
        checkOutput("lu_add_reg_dst", ex_reg_dst, 1);

        $display("[TB] load to r0 does not stall");
        applyStimulus(EX_LW, M_LW, WB_LW, 5'd3, 5'd0, 5'd0);
        sbQ.push_back({1'b1, 5'd0});
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd0, 5'd0, 5'd11);
        sbQ.push_back({1'b0, 5'd11});
        checkOutput("r0_pc_write", pc_write, 1);
        checkOutput("r0_ifid_write", ifid_write, 1);
        tick();
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_add_reg_dst", ex_reg_dst, 1);
        checkStall("r0");
        drain(4);

        $display("[TB] taken branch flushes two younger bundles");
        applyStimulus(EX_BEQ, M_BEQ, WB_NOP, 5'd1, 5'd2, 5'd0);
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd12);
        tick();
        mem_zero = 1'b1;
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd13);
        checkOutput("bt_pc_src", pc_src, 1);
        checkOutput("bt_ifid_flush", ifid_flush, 1);
        checkOutput("bt_pc_write", pc_write, 1);
        checkOutput("bt_ifid_write", ifid_write, 1);
        tick();
        mem_zero = 1'b0;
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("bt_idex_bubble", ex_reg_dst, 0);
        checkOutput("bt_exmem_mem_read", mem_read, 0);
        checkOutput("bt_exmem_mem_write", mem_write, 0);
        tick();
        checkOutput("bt_wb1_reg_write", wb_reg_write, 0);
        checkOutput("bt_mem_write2", mem_write, 0);
        tick();
        checkOutput("bt_wb2_reg_write", wb_reg_write, 0);
        checkStall("bt");
        drain(2);

        $display("[TB] untaken branch");
        applyStimulus(EX_BEQ, M_BEQ, WB_NOP, 5'd1, 5'd2, 5'd0);
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd14);
        sbQ.push_back({1'b0, 5'd14});
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd15);
        sbQ.push_back({1'b0, 5'd15});
        checkOutput("bn_pc_src", pc_src, 0);
        checkOutput("bn_ifid_flush", ifid_flush, 0);
        tick();
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("bn_younger_reg_dst", ex_reg_dst, 1);
        drain(4);

        $display("[TB] store with three wait states");
        applyStimulus(EX_SW, M_SW, WB_NOP, 5'd4, 5'd5, 5'd0);
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd16);
        sbQ.push_back({1'b0, 5'd16});
        tick();
        mem_ready = 1'b0;
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd17);
        sbQ.push_back({1'b0, 5'd17});
        checkOutput("ws_mem_busy", mem_busy, 1);
        checkOutput("ws_pc_write", pc_write, 0);
        checkOutput("ws_ifid_write", ifid_write, 0);
        checkOutput("ws_ifid_flush", ifid_flush, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            expCnt++;
            if (k == 3) mem_ready = 1'b1;
            #1;
            checkOutput("ws_hold_mem_write", mem_write, 1);
            checkOutput("ws_hold_reg_dst", ex_reg_dst, 1);
            checkOutput("ws_wb_bubble", wb_reg_write, 0);
            checkOutput("ws_busy_hold", mem_busy, 1);
            checkOutput("ws_pc_write_hold", pc_write, (k == 3) ? 1 : 0);
            checkStall("ws");
        end
        tick();
        applyStimulus(EX_NOP, M_NOP, WB_NOP, 5'd0, 5'd0, 5'd0);
        checkOutput("ws_adv_mem_write", mem_write, 0);
        checkOutput("ws_adv_mem_busy", mem_busy, 0);
        checkOutput("ws_adv_reg_dst", ex_reg_dst, 1);
        checkStall("ws_adv");
        drain(4);
        checkOutput("sb_drained", sbQ.size(), 0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd18);
        tick();
        applyStimulus(EX_R, M_R, WB_R, 5'd1, 5'd2, 5'd19);
        tick();
        rst = 1'b1;
        expCnt = 0;
        #1;
        checkOutput("ar_ex_reg_dst", ex_reg_dst, 0);
        checkOutput("ar_mem_read", mem_read, 0);
        checkOutput("ar_wb_reg_write", wb_reg_write, 0);
        checkOutput("ar_wb_dest", wb_dest, 0);
        checkOutput("ar_pc_write", pc_write, 1);
        checkOutput("ar_mem_busy", mem_busy, 0);
        checkStall("ar");
        drain(2);
        rst = 1'b0;
        drain(4);
        checkOutput("ar_no_write", wb_reg_write, 0);

        $display("[TB] back-to-back load-use, counter saturation");
        applyStimulus(EX_LW, M_LW, WB_LW, 5'd8, 5'd8, 5'd0);
        sbQ.push_back({1'b1, 5'd8});
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("sat_pc_write", pc_write, 0);
            tick();
            expCnt++;
            checkOutput("sat_bubble", ex_alu_src, 0);
            checkStall("sat");
            sbQ.push_back({1'b1, 5'd8});
            tick();
        end
        drain(5);
        checkOutput("sb_empty", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receiving end of the decoder's control bundles EX[2:0]={RegDst,ALUOp,ALUSrc}, M[2:0]={Branch,MemRead,MemWrite}, WB[1:0]={RegWrite,MemtoReg}.
- Carries each bundle down the ID/EX, EX/MEM and MEM/WB pipeline registers and presents each stage's controls to the datapath.
- Owns load-use hazard detection, branch flush and memory wait-state freeze for the 5-stage MIPS pipeline.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_in  in  3  EX bundle from the decoder (ID stage).
- m_in  in  3  M bundle from the decoder.
- wb_in  in  2  WB bundle from the decoder.
- id_rs  in  REG_W  rs of the instruction in ID.
- id_rt  in  REG_W  rt of the instruction in ID.
- id_rd  in  REG_W  rd of the instruction in ID.
- mem_zero  in  1  ALU zero flag registered into EX/MEM.
- mem_ready  in  1  data memory handshake; 1 = access completes this cycle.
- ex_reg_dst, ex_alu_op, ex_alu_src  out  1 each  EX-stage controls (ID/EX register).
- mem_read, mem_write  out  1 each  MEM-stage controls (EX/MEM register).
- pc_src  out  1  branch taken.
- wb_reg_write, wb_mem_to_reg  out  1 each  WB-stage controls (MEM/WB register).
- wb_dest  out  REG_W  write-back register number.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- mem_busy  out  1  FSM in WAIT.
- stall_cnt  out  CNT_W  total stall and freeze cycles, saturating.

Behaviour:
- Reset (async, rst=1): all stage registers = 0 (bubble), FSM = RUN, stall_cnt = 0.
  - Resulting outputs: every control output 0, wb_dest 0, pc_src 0, pc_write 1, ifid_write 1, ifid_flush 0, mem_busy 0.
  - Reset mid-operation discards all in-flight bundles immediately.
- Destination at ID: dest = RegDst ? id_rd : id_rt; forced to 0 when wb_in RegWrite=0.
  - Don't-care (X) bundle bits are therefore never used in dest or hazard logic.
- Bundle latency:
  - EX controls appear 1 cycle after capture.
  - Branch/MemRead/MemWrite appear 2 cycles after capture.
  - WB controls and wb_dest appear 3 cycles after capture.
- Combinational terms:
  - load_use = idex.MemRead & idex.dest≠0 & (idex.dest==id_rs | idex.dest==id_rt).
  - pc_src = exmem.Branch & mem_zero.
  - wait = (exmem.MemRead | exmem.MemWrite) & ~mem_ready.
- Priority per cycle: wait > pc_src > load_use > normal advance.
- wait:
  - ID/EX and EX/MEM hold; MEM/WB <= bubble (no repeated write-back).
  - pc_write=0, ifid_write=0, ifid_flush=0.
- pc_src (no wait):
  - ID/EX <= bubble, EX/MEM <= bubble, MEM/WB <= EX/MEM.
  - ifid_flush=1, pc_write=1, ifid_write=1.
- load_use (no wait, no pc_src):
  - ID/EX <= bubble; EX/MEM and MEM/WB advance.
  - pc_write=0, ifid_write=0.
- normal: ID/EX <= {ex_in, m_in, wb_in, dest}; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
- Bubble is an all-zero bundle with dest 0.
- FSM:
  - RUN -> WAIT when wait=1.
  - WAIT stays while wait=1; WAIT -> RUN on the cycle mem_ready=1, when the access completes and the pipeline advances that same edge.
  - mem_busy = (state==WAIT) | wait.
- stall_cnt: +1 on each edge where wait or load_use is asserted (not pc_src alone); holds at 2^CNT_W-1.
- Simultaneous pc_src and wait are impossible (beq has no memory access); if both are forced, wait wins and pc_src is still output.

Test Plan:
- R-type (ex 110, m 000, wb 10, rd=5) with no hazards -> ex_reg_dst=1 at +1; wb_reg_write=1, wb_dest=5 at +3; pc_write and ifid_write stay 1.
- lw rt=8, followed by add with rs=8 -> one load_use cycle: pc_write=0, ifid_write=0, next ex_alu_op=0 (bubble), stall_cnt=1; add issues one cycle later. Repeat with rt=0 -> no stall.
- beq followed by two instructions, mem_zero=1 at beq's MEM cycle -> pc_src=1, ifid_flush=1; both younger bundles become bubbles (mem_read=mem_write=wb_reg_write=0 downstream); mem_zero=0 -> no flush.
- sw in MEM with mem_ready low for 3 cycles -> mem_write held 1, mem_busy=1, pc_write=0 for 3 cycles, MEM/WB bubbles, stall_cnt=3; advance on the 4th edge.
- rst asserted asynchronously mid-stream (between edges) -> outputs zero immediately, pc_write=1, stall_cnt=0, FSM RUN; opcode-default bundle (all 0) produces no writes.
- Force stall_cnt to 2^CNT_W-2, then 3 load_use cycles -> counter saturates at 0xFFFF.
